// File: rtl/camera_pio_pkg.sv
// camera_pio_pkg: register addresses and edge-select codes shared by the camera PIO slaves
package camera_pio_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam logic [1:0] EDGE_RISE    = 2'd0;
    localparam logic [1:0] EDGE_FALL    = 2'd1;
    localparam logic [1:0] EDGE_ANY     = 2'd2;
endpackage

// File: rtl/camera_key_pio_if.sv
// camera_key_pio_if: Avalon-MM slave bus for the key input port
interface camera_key_pio_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, read, write, writedata, input readdata);
    modport slave(input address, read, write, writedata, output readdata);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: one input bit -- 2-flop synchroniser, stability counter, debounced level, edge pulse
module key_debounce
    import camera_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [1:0] EDGE_TYPE = EDGE_FALL,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o,
    output logic edge_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync_q;
    logic deb_q, diff, settle;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        diff = sync_q[1] ^ deb_q;
        settle = diff && cnt_q == LAST;
        cnt_d = (diff && !settle) ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            deb_q <= deb_q ^ settle;
            cnt_q <= cnt_d;
        end
    end
    // on a settle the synchronised bit is the new level, so it gives the edge direction
    assign edge_o = settle && (EDGE_TYPE == EDGE_ANY || ((EDGE_TYPE == EDGE_RISE) == sync_q[1]));
    assign deb_o = deb_q;
endmodule

// File: rtl/camera_key_pio.sv
// camera_key_pio: Avalon-MM key/switch input port with debounce, edge capture and maskable IRQ
module camera_key_pio
    import camera_pio_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [1:0] EDGE_TYPE = EDGE_FALL,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    camera_key_pio_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] deb, edge_hit, wdata, mask_q, mask_d, ec_q, ec_d;
    logic [31:0] rd_q, rd_d;
    logic irq_q, irq_d;
    for (genvar b = 0; b < WIDTH; b++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE(EDGE_TYPE),
            .CNT_W(CNT_W)
        ) u_key (
            .clk(clk),
            .reset(reset),
            .raw_i(in_port[b]),
            .deb_o(deb[b]),
            .edge_o(edge_hit[b])
        );
    end
    always_comb begin
        wdata = WIDTH'(bus.writedata);
        mask_d = (bus.write && bus.address == ADDR_IRQMASK) ? wdata : mask_q;
        // a new edge beats a same-cycle write-1-to-clear
        ec_d = (ec_q & ~((bus.write && bus.address == ADDR_EDGECAP) ? wdata : '0)) | edge_hit;
        rd_d = !bus.read ? rd_q :
               bus.address == ADDR_DATA    ? 32'(deb) :
               bus.address == ADDR_IRQMASK ? 32'(mask_q) :
               bus.address == ADDR_EDGECAP ? 32'(ec_q) : '0;
        irq_d = |(ec_q & mask_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            ec_q <= '0;
            rd_q <= '0;
            irq_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            ec_q <= ec_d;
            rd_q <= rd_d;
            irq_q <= irq_d;
        end
    end
    assign bus.readdata = rd_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_camera_key_pio.sv
// tb_camera_key_pio: directed, table-driven and randomized checks against a sliding-window reference model
module tb_camera_key_pio;
    localparam int W = 4;
    localparam int D = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] in_port = '0;
    logic irq;
    int errors = 0;
    int checks = 0;
    camera_key_pio_if bus();
    camera_key_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2'd1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .in_port(in_port), .irq(irq)
    );
    always #5 clk = ~clk;

    // Reference: a bit flips once the last D synchronised samples (raw delayed by 2) all disagree with it.
    logic [W-1:0] h [1:D+1];
    logic [W-1:0] m_deb, m_mask, m_ec, m_flip;
    logic [31:0] m_rd;
    logic m_irq;
    always_comb begin
        m_flip = '1;
        for (int k = 2; k <= D + 1; k++) m_flip = m_flip & (h[k] ^ m_deb);
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= D + 1; k++) h[k] <= '0;
            m_deb <= '0;
            m_mask <= '0;
            m_ec <= '0;
            m_rd <= '0;
            m_irq <= 1'b0;
        end else begin
            h[1] <= in_port;
            for (int k = 2; k <= D + 1; k++) h[k] <= h[k-1];
            m_deb <= m_deb ^ m_flip;
            if (bus.write && bus.address == 2'd2) m_mask <= bus.writedata[W-1:0];
            m_ec <= (m_ec & ~((bus.write && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0)) | (m_flip & m_deb);
            if (bus.read) m_rd <= bus.address == 2'd0 ? 32'(m_deb) : bus.address == 2'd2 ? 32'(m_mask) :
                                  bus.address == 2'd3 ? 32'(m_ec) : 32'd0;
            m_irq <= |(m_ec & m_mask);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
        bus.write = w;
        bus.read = r;
        bus.address = a;
        bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
        bus.read = 1'b0;
    endtask

    typedef struct {
        logic w;
        logic r;
        logic [1:0] a;
        logic [31:0] d;
        logic chk;
        logic [31:0] exp;
        string name;
    } vec_t;
    vec_t vecs[13];

    initial begin
        int lat;
        logic seen;
        vecs = '{
            '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h0, "mask_wr"},
            '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'hF, "mask_width"},
            '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0, "rsvd_rd"},
            '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, "rsvd_wr"},
            '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0, "rsvd_after_wr"},
            '{1'b1, 1'b0, 2'd0, 32'h5,         1'b0, 32'h0, "data_wr"},
            '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'hA, "data_ro"},
            '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'hA, "rd_hold"},
            '{1'b1, 1'b1, 2'd2, 32'h3,         1'b1, 32'hF, "rw_prewrite"},
            '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h3, "mask_after"},
            '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h1, "ec_bit0"},
            '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0, "ec_clr"},
            '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h0, "ec_clr_all"}
        };
        bus.address = 2'd0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        repeat (2) @(negedge clk);
        check("reset_rd", bus.readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        bus_op(1'b0, 1'b1, 2'd0, 32'h0);
        check("rd0_after_reset", bus.readdata, 32'h0);
        // debounce latency: change lands on edge 10, a continuous read shows it after edge 11
        in_port = 4'b0001;
        bus.read = 1'b1;
        bus.address = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) check("deb_not_early", bus.readdata, 32'h0);
            if (k == 11) check("deb_settled", bus.readdata, 32'h1);
        end
        seen = 1'b0;
        in_port = 4'b0011;
        repeat (5) @(negedge clk) seen |= bus.readdata[1];
        in_port = 4'b0001;
        repeat (20) @(negedge clk) seen |= bus.readdata[1];
        check("glitch_hidden", 32'(seen), 32'h0);
        bus.read = 1'b0;
        // keys idle high, then press bit 2
        in_port = 4'hF;
        repeat (14) @(negedge clk);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_no_rise", bus.readdata, 32'h0);
        in_port = 4'hB;
        repeat (12) @(negedge clk);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_press", bus.readdata, 32'h4);
        bus_op(1'b1, 1'b0, 2'd3, 32'h0);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_write0", bus.readdata, 32'h4);
        bus_op(1'b1, 1'b0, 2'd3, 32'h4);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_w1c", bus.readdata, 32'h0);
        // irq path
        bus_op(1'b1, 1'b0, 2'd2, 32'h4);
        in_port = 4'hF;
        repeat (12) @(negedge clk);
        check("irq_no_rise", 32'(irq), 32'h0);
        in_port = 4'hB;
        bus.read = 1'b1;
        bus.address = 2'd3;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (irq) lat = k;
        end
        check("irq_latency", 32'(lat), 32'd11);
        check("irq_with_ec", bus.readdata, 32'h4);
        bus.read = 1'b0;
        bus_op(1'b1, 1'b0, 2'd2, 32'h0);
        check("irq_old_mask", 32'(irq), 32'h1);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("irq_unmasked", 32'(irq), 32'h0);
        check("ec_retained", bus.readdata, 32'h4);
        bus_op(1'b1, 1'b0, 2'd3, 32'h4);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("irq_after_clr", 32'(irq), 32'h0);
        check("ec_cleared", bus.readdata, 32'h0);
        // bit 0 falls on the same edge as a write-1-to-clear of bit 0
        in_port = 4'hA;
        repeat (9) @(negedge clk);
        bus_op(1'b1, 1'b0, 2'd3, 32'h1);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_set_wins", bus.readdata, 32'h1);
        for (int i = 0; i < 13; i++) begin
            bus_op(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) check(vecs[i].name, bus.readdata, vecs[i].exp);
        end
        // reset in the middle of a debounce and a read
        in_port = 4'h5;
        bus.read = 1'b1;
        bus.address = 2'd0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_rd", bus.readdata, 32'h0);
        check("reset_mid_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) check("redeb_not_early", bus.readdata, 32'h0);
            if (k == 11) check("redeb_settled", bus.readdata, 32'h5);
        end
        bus_op(1'b0, 1'b1, 2'd2, 32'h0);
        check("mask_after_reset", bus.readdata, 32'h0);
        bus_op(1'b0, 1'b1, 2'd3, 32'h0);
        check("ec_after_reset", bus.readdata, 32'h0);
        // randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            check("rand_rd", bus.readdata, m_rd);
            check("rand_irq", 32'(irq), 32'(m_irq));
            for (int b = 0; b < W; b++) if ($urandom_range(11) == 0) in_port[b] = ~in_port[b];
            bus.address = 2'($urandom_range(3));
            bus.read = 1'($urandom_range(1));
            bus.write = $urandom_range(3) == 0;
            bus.writedata = $urandom;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
